// File: rtl/gpi_cond_pkg.sv
// Shared types for the GPI input conditioner: filter FSM states, the
// EDGE_SEL_I encodings and the edge-to-interrupt decode.
package gpi_cond_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'b00,
    RISE_PEND = 2'b01,
    HIGH      = 2'b10,
    FALL_PEND = 2'b11
  } filt_state_t;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // True when an observed edge pulse is one the edge select asks for.
  function automatic logic edge_hit(logic [1:0] sel, logic rise, logic fall);
    return (rise && (sel == EDGE_RISE || sel == EDGE_BOTH)) ||
           (fall && (sel == EDGE_FALL || sel == EDGE_BOTH));
  endfunction

endpackage

// File: rtl/gpi_input_conditioner_if.sv
// Pin-side bundle of the GPI input conditioner.
// There is no valid/ready handshake on this bundle: DI_I is an asynchronous
// level, IE_I/FILT_LEN_I/EDGE_SEL_I are quasi-static levels sampled every
// cycle, IRQ_CLR_I is a single-cycle strobe, and every output is a level or a
// one-cycle pulse valid on every rising clock edge.
// filt_state exposes the filter FSM state for observation.
interface gpi_input_conditioner_if
  import gpi_cond_pkg::*;
#(parameter int CNT_W = 8);

  logic             DI_I;
  logic             IE_I;
  logic [CNT_W-1:0] FILT_LEN_I;
  logic [1:0]       EDGE_SEL_I;
  logic             IRQ_CLR_I;
  logic             DI_O;
  logic             RISE_O;
  logic             FALL_O;
  logic             IRQ_O;
  filt_state_t      filt_state;

  modport master (
    output DI_I, IE_I, FILT_LEN_I, EDGE_SEL_I, IRQ_CLR_I,
    input  DI_O, RISE_O, FALL_O, IRQ_O, filt_state
  );

  modport slave (
    input  DI_I, IE_I, FILT_LEN_I, EDGE_SEL_I, IRQ_CLR_I,
    output DI_O, RISE_O, FALL_O, IRQ_O, filt_state
  );

endinterface

// File: rtl/gpi_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
// SYNC_STAGES must be at least 2; all flops reset to 0.
module gpi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  // Shift chain; nothing but the flop sits on the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/gpi_input_conditioner.sv
// GPI input conditioner: synchronizer, optional glitch filter, edge pulses
// and a sticky interrupt request.
// Macro GPI_GLITCH_FILTER_EN enables the FILT_LEN_I glitch filter; without it
// DI_O is the synchronized input registered once and FILT_LEN_I is ignored.
module gpi_input_conditioner
  import gpi_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input logic                    CLK_I,
  input logic                    RST_I,
  gpi_input_conditioner_if.slave bus
);

  logic sync_in;
  logic s;
  logic lvl;
  logic lvl_prev;
  logic rise;
  logic fall;
  logic irq_q;

  // Enable gating happens before the first flop so a disabled pad reads 0.
  assign sync_in = bus.DI_I & bus.IE_I;

  gpi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (CLK_I),
    .rst (RST_I),
    .d   (sync_in),
    .q   (s)
  );

`ifdef GPI_GLITCH_FILTER_EN
  filt_state_t      state;
  logic [CNT_W-1:0] cnt;

  // Filter FSM: a new level is accepted after FILT_LEN_I+1 identical samples.
  // FILT_LEN_I is compared live and cnt never passes it, so no wrap occurs.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state <= LOW;
      cnt   <= '0;
    end else begin
      case (state)
        LOW: begin
          if (s) begin
            if (bus.FILT_LEN_I == '0) state <= HIGH;
            else begin
              state <= RISE_PEND;
              cnt   <= CNT_W'(1);
            end
          end
        end
        RISE_PEND: begin
          if (!s) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt >= bus.FILT_LEN_I) begin
            state <= HIGH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HIGH: begin
          if (!s) begin
            if (bus.FILT_LEN_I == '0) state <= LOW;
            else begin
              state <= FALL_PEND;
              cnt   <= CNT_W'(1);
            end
          end
        end
        FALL_PEND: begin
          if (s) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt >= bus.FILT_LEN_I) begin
            state <= LOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign lvl            = (state == HIGH) || (state == FALL_PEND);
  assign bus.filt_state = state;
`else
  logic             lvl_q;
  logic [CNT_W-1:0] unused_filt_len;

  // Without the filter the synchronized level is simply registered once.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) lvl_q <= 1'b0;
    else       lvl_q <= s;
  end

  assign lvl             = lvl_q;
  assign bus.filt_state  = lvl_q ? HIGH : LOW;
  assign unused_filt_len = bus.FILT_LEN_I;
`endif

  // Previous output level, used to form pulses in the cycle DI_O changes.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) lvl_prev <= 1'b0;
    else       lvl_prev <= lvl;
  end

  assign rise = lvl & ~lvl_prev;
  assign fall = ~lvl & lvl_prev;

  // Sticky interrupt: an enabled edge sets it, the clear strobe drops it,
  // and a simultaneous set beats the clear.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I)                                 irq_q <= 1'b0;
    else if (edge_hit(bus.EDGE_SEL_I, rise, fall)) irq_q <= 1'b1;
    else if (bus.IRQ_CLR_I)                    irq_q <= 1'b0;
  end

  assign bus.DI_O   = lvl;
  assign bus.RISE_O = rise;
  assign bus.FALL_O = fall;
  assign bus.IRQ_O  = irq_q;

endmodule

// File: tb/tb_gpi_input_conditioner.sv
// Self-checking bench for gpi_input_conditioner. Builds with or without
// GPI_GLITCH_FILTER_EN; the reference model and directed checks follow the
// same macro.
module tb_gpi_input_conditioner;
  import gpi_cond_pkg::*;

  localparam int SYNC  = 2;
  localparam int CNT_W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [3:0] exp_q[$];
  logic [3:0] exp_v;
  logic [3:0] obs_v;

  gpi_input_conditioner_if #(.CNT_W(CNT_W)) bus ();

  gpi_input_conditioner #(.SYNC_STAGES(SYNC), .CNT_W(CNT_W)) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .bus   (bus)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model: predicts {DI_O, RISE_O, FALL_O, IRQ_O} after each edge.
  logic [SYNC-1:0] m_sync;
  logic m_lvl, m_rise, m_fall, m_irq, m_s, m_nl, m_set;
`ifdef GPI_GLITCH_FILTER_EN
  int m_run;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sync = '0; m_lvl = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_irq = 1'b0;
`ifdef GPI_GLITCH_FILTER_EN
      m_run = 0;
`endif
      exp_q.delete();
    end else begin
      m_s   = m_sync[SYNC-1];
      m_set = (m_rise && bus.EDGE_SEL_I[0]) || (m_fall && bus.EDGE_SEL_I[1]);
      if (m_set) m_irq = 1'b1;
      else if (bus.IRQ_CLR_I) m_irq = 1'b0;
`ifdef GPI_GLITCH_FILTER_EN
      // Run-length view: flip once the opposite value has been seen
      // FILT_LEN_I+1 times in a row.
      if (m_s != m_lvl) begin
        m_run = m_run + 1;
        if (m_run >= int'(bus.FILT_LEN_I) + 1) begin
          m_nl  = ~m_lvl;
          m_run = 0;
        end else begin
          m_nl = m_lvl;
        end
      end else begin
        m_run = 0;
        m_nl  = m_lvl;
      end
`else
      m_nl = m_s;
`endif
      m_rise = m_nl & ~m_lvl;
      m_fall = ~m_nl & m_lvl;
      m_lvl  = m_nl;
      m_sync = {m_sync[SYNC-2:0], bus.DI_I & bus.IE_I};
      exp_q.push_back({m_lvl, m_rise, m_fall, m_irq});
    end
  end

  // Driver: hold reset for two cycles with idle inputs, release on a negedge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.DI_I = 1'b0; bus.IE_I = 1'b1; bus.FILT_LEN_I = '0;
    bus.EDGE_SEL_I = EDGE_NONE; bus.IRQ_CLR_I = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.DI_I = 1'b1; bus.IE_I = 1'b1; bus.FILT_LEN_I = '0;
    bus.EDGE_SEL_I = EDGE_BOTH; bus.IRQ_CLR_I = 1'b0;
    repeat (3) @(negedge clk);
    obs_v = {bus.DI_O, bus.RISE_O, bus.FALL_O, bus.IRQ_O};
    checks++;
    if (obs_v !== 4'b0000) begin
      failures++; $display("FAIL reset_outputs got=%b exp=0000", obs_v);
    end
    checks++;
    if (bus.filt_state !== LOW) begin
      failures++; $display("FAIL reset_state got=%0d exp=%0d", bus.filt_state, LOW);
    end
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL reset_sb_empty cycle=%0d", k);
      end else begin
        exp_v = exp_q.pop_front();
        obs_v = {bus.DI_O, bus.RISE_O, bus.FALL_O, bus.IRQ_O};
        if (obs_v !== exp_v) begin
          failures++; $display("FAIL reset_sb cycle=%0d got=%b exp=%b", k, obs_v, exp_v);
        end
      end
      if (k == 3) begin
        checks++;
        if ({bus.DI_O, bus.RISE_O} !== 2'b11) begin
          failures++; $display("FAIL reset_release_rise got=%b exp=11", {bus.DI_O, bus.RISE_O});
        end
      end
    end
  endtask

  // Set/clear collision on the same cycle; set must win.
  task automatic test_irq_collision();
    do_reset();
    bus.EDGE_SEL_I = EDGE_BOTH; bus.DI_I = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL coll_sb_empty cycle=%0d", k);
      end else begin
        exp_v = exp_q.pop_front();
        obs_v = {bus.DI_O, bus.RISE_O, bus.FALL_O, bus.IRQ_O};
        if (obs_v !== exp_v) begin
          failures++; $display("FAIL coll_sb cycle=%0d got=%b exp=%b", k, obs_v, exp_v);
        end
      end
      case (k)
        4: bus.IRQ_CLR_I = 1'b1;
        5: begin
          checks++;
          if (bus.IRQ_O !== 1'b0) begin
            failures++; $display("FAIL coll_pre_clear got=%b exp=0", bus.IRQ_O);
          end
          bus.IRQ_CLR_I = 1'b0; bus.DI_I = 1'b0;
        end
        8: begin
          checks++;
          if (bus.FALL_O !== 1'b1) begin
            failures++; $display("FAIL coll_fall got=%b exp=1", bus.FALL_O);
          end
          bus.IRQ_CLR_I = 1'b1;
        end
        9: begin
          checks++;
          if (bus.IRQ_O !== 1'b1) begin
            failures++; $display("FAIL coll_set_wins got=%b exp=1", bus.IRQ_O);
          end
        end
        10: begin
          checks++;
          if (bus.IRQ_O !== 1'b0) begin
            failures++; $display("FAIL coll_clear got=%b exp=0", bus.IRQ_O);
          end
          bus.IRQ_CLR_I = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  // Edge select gates IRQ setting but never disturbs a pending IRQ.
  task automatic test_edge_sel();
    do_reset();
    bus.EDGE_SEL_I = EDGE_RISE; bus.DI_I = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL esel_sb_empty cycle=%0d", k);
      end else begin
        exp_v = exp_q.pop_front();
        obs_v = {bus.DI_O, bus.RISE_O, bus.FALL_O, bus.IRQ_O};
        if (obs_v !== exp_v) begin
          failures++; $display("FAIL esel_sb cycle=%0d got=%b exp=%b", k, obs_v, exp_v);
        end
      end
      case (k)
        4: begin
          checks++;
          if (bus.IRQ_O !== 1'b1) begin
            failures++; $display("FAIL esel_rise_irq got=%b exp=1", bus.IRQ_O);
          end
          bus.EDGE_SEL_I = EDGE_NONE;
        end
        6: bus.EDGE_SEL_I = EDGE_FALL;
        8: begin
          checks++;
          if (bus.IRQ_O !== 1'b1) begin
            failures++; $display("FAIL esel_pending_kept got=%b exp=1", bus.IRQ_O);
          end
          bus.IRQ_CLR_I = 1'b1;
        end
        9: begin
          bus.IRQ_CLR_I = 1'b0; bus.DI_I = 1'b0; bus.EDGE_SEL_I = EDGE_RISE;
        end
        14: begin
          checks++;
          if (bus.IRQ_O !== 1'b0) begin
            failures++; $display("FAIL esel_fall_masked got=%b exp=0", bus.IRQ_O);
          end
        end
        default: ;
      endcase
    end
  endtask

  // Random traffic across all inputs, checked cycle by cycle.
  task automatic test_random();
    do_reset();
    for (int k = 1; k <= 400; k++) begin
      bus.DI_I       = 1'($urandom_range(0, 1));
      bus.IE_I       = ($urandom_range(0, 7) != 0);
      bus.EDGE_SEL_I = 2'($urandom_range(0, 3));
      bus.IRQ_CLR_I  = ($urandom_range(0, 7) == 0);
`ifdef GPI_GLITCH_FILTER_EN
      if ($urandom_range(0, 15) == 0) bus.FILT_LEN_I = CNT_W'($urandom_range(0, 3));
`else
      bus.FILT_LEN_I = CNT_W'($urandom_range(0, 255));
`endif
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL rand_sb_empty cycle=%0d", k);
      end else begin
        exp_v = exp_q.pop_front();
        obs_v = {bus.DI_O, bus.RISE_O, bus.FALL_O, bus.IRQ_O};
        if (obs_v !== exp_v) begin
          failures++; $display("FAIL rand_sb cycle=%0d got=%b exp=%b", k, obs_v, exp_v);
        end
      end
    end
  endtask

`ifdef GPI_GLITCH_FILTER_EN
  // FILT_LEN_I=3: level accepted 6 cycles after DI_I rises, IRQ follows.
  task automatic test_filter_pass();
    int rises;
    rises = 0;
    do_reset();
    bus.FILT_LEN_I = 8'd3; bus.EDGE_SEL_I = EDGE_RISE; bus.DI_I = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL pass_sb_empty cycle=%0d", k);
      end else begin
        exp_v = exp_q.pop_front();
        obs_v = {bus.DI_O, bus.RISE_O, bus.FALL_O, bus.IRQ_O};
        if (obs_v !== exp_v) begin
          failures++; $display("FAIL pass_sb cycle=%0d got=%b exp=%b", k, obs_v, exp_v);
        end
      end
      if (bus.RISE_O === 1'b1) rises++;
      if (k == 5) begin
        checks++;
        if (bus.DI_O !== 1'b0) begin
          failures++; $display("FAIL pass_early got=%b exp=0", bus.DI_O);
        end
      end
      if (k == 6) begin
        checks++;
        if ({bus.DI_O, bus.RISE_O} !== 2'b11) begin
          failures++; $display("FAIL pass_at6 got=%b exp=11", {bus.DI_O, bus.RISE_O});
        end
      end
      if (k == 7) begin
        checks++;
        if (bus.IRQ_O !== 1'b1) begin
          failures++; $display("FAIL pass_irq got=%b exp=1", bus.IRQ_O);
        end
      end
    end
    checks++;
    if (rises !== 1) begin
      failures++; $display("FAIL pass_rise_count got=%0d exp=1", rises);
    end
  endtask

  // A 3-cycle pulse with FILT_LEN_I=3 must vanish completely.
  task automatic test_glitch();
    logic [3:0] seen;
    seen = '0;
    do_reset();
    bus.FILT_LEN_I = 8'd3; bus.EDGE_SEL_I = EDGE_BOTH; bus.DI_I = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL glitch_sb_empty cycle=%0d", k);
      end else begin
        exp_v = exp_q.pop_front();
        obs_v = {bus.DI_O, bus.RISE_O, bus.FALL_O, bus.IRQ_O};
        if (obs_v !== exp_v) begin
          failures++; $display("FAIL glitch_sb cycle=%0d got=%b exp=%b", k, obs_v, exp_v);
        end
      end
      seen = seen | {bus.DI_O, bus.RISE_O, bus.FALL_O, bus.IRQ_O};
      if (k == 3) bus.DI_I = 1'b0;
    end
    checks++;
    if (seen !== 4'b0000) begin
      failures++; $display("FAIL glitch_quiet got=%b exp=0000", seen);
    end
  endtask

  // FILT_LEN_I=0 passes a 1-cycle pulse; IE_I=0 masks the pad.
  task automatic test_zero_len_enable();
    do_reset();
    bus.FILT_LEN_I = '0; bus.DI_I = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL zlen_sb_empty cycle=%0d", k);
      end else begin
        exp_v = exp_q.pop_front();
        obs_v = {bus.DI_O, bus.RISE_O, bus.FALL_O, bus.IRQ_O};
        if (obs_v !== exp_v) begin
          failures++; $display("FAIL zlen_sb cycle=%0d got=%b exp=%b", k, obs_v, exp_v);
        end
      end
      if (k == 1) bus.DI_I = 1'b0;
      if (k == 3 && bus.DI_O !== 1'b1) begin
        failures++; $display("FAIL zlen_pulse got=%b exp=1", bus.DI_O);
      end
      if (k == 3) checks++;
      if (k == 4) begin
        checks++;
        if ({bus.DI_O, bus.FALL_O} !== 2'b01) begin
          failures++; $display("FAIL zlen_fall got=%b exp=01", {bus.DI_O, bus.FALL_O});
        end
        bus.IE_I = 1'b0; bus.DI_I = 1'b1;
      end
      if (k == 16) begin
        checks++;
        if (bus.DI_O !== 1'b0) begin
          failures++; $display("FAIL ie_masked got=%b exp=0", bus.DI_O);
        end
      end
    end
  endtask

  // Lowering FILT_LE_I below cnt completes the pend on the next edge.
  task automatic test_len_lowered();
    do_reset();
    bus.FILT_LEN_I = 8'd200; bus.DI_I = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL lower_sb_empty cycle=%0d", k);
      end else begin
        exp_v = exp_q.pop_front();
        obs_v = {bus.DI_O, bus.RISE_O, bus.FALL_O, bus.IRQ_O};
        if (obs_v !== exp_v) begin
          failures++; $display("FAIL lower_sb cycle=%0d got=%b exp=%b", k, obs_v, exp_v);
        end
      end
      if (k == 12) begin
        checks++;
        if (bus.DI_O !== 1'b0) begin
          failures++; $display("FAIL lower_before got=%b exp=0", bus.DI_O);
        end
        bus.FILT_LEN_I = 8'd5;
      end
      if (k == 13) begin
        checks++;
        if ({bus.DI_O, bus.RISE_O} !== 2'b11) begin
          failures++; $display("FAIL lower_flip got=%b exp=11", {bus.DI_O, bus.RISE_O});
        end
      end
    end
  endtask

  // Reset during a pend discards the count; full latency applies afterwards.
  task automatic test_reset_midpend();
    do_reset();
    bus.FILT_LEN_I = 8'd20; bus.DI_I = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL midrst_sb_empty cycle=%0d", k);
      end else begin
        exp_v = exp_q.pop_front();
        obs_v = {bus.DI_O, bus.RISE_O, bus.FALL_O, bus.IRQ_O};
        if (obs_v !== exp_v) begin
          failures++; $display("FAIL midrst_sb cycle=%0d got=%b exp=%b", k, obs_v, exp_v);
        end
      end
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    obs_v = {bus.DI_O, bus.RISE_O, bus.FALL_O, bus.IRQ_O};
    checks++;
    if (obs_v !== 4'b0000 || bus.filt_state !== LOW) begin
      failures++; $display("FAIL midrst_outputs got=%b/%0d exp=0000/0", obs_v, bus.filt_state);
    end
    rst = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL midrst2_sb_empty cycle=%0d", k);
      end else begin
        exp_v = exp_q.pop_front();
        obs_v = {bus.DI_O, bus.RISE_O, bus.FALL_O, bus.IRQ_O};
        if (obs_v !== exp_v) begin
          failures++; $display("FAIL midrst2_sb cycle=%0d got=%b exp=%b", k, obs_v, exp_v);
        end
      end
      if (k == 22) begin
        checks++;
        if (bus.DI_O !== 1'b0) begin
          failures++; $display("FAIL midrst_early got=%b exp=0", bus.DI_O);
        end
      end
      if (k == 23) begin
        checks++;
        if ({bus.DI_O, bus.RISE_O} !== 2'b11) begin
          failures++; $display("FAIL midrst_rise got=%b exp=11", {bus.DI_O, bus.RISE_O});
        end
      end
    end
  endtask

  // FILT_LEN_I=all-ones is legal: 258-cycle latency with no counter wrap.
  task automatic test_len_max();
    do_reset();
    bus.FILT_LEN_I = '1; bus.DI_I = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL max_sb_empty cycle=%0d", k);
      end else begin
        exp_v = exp_q.pop_front();
        obs_v = {bus.DI_O, bus.RISE_O, bus.FALL_O, bus.IRQ_O};
        if (obs_v !== exp_v) begin
          failures++; $display("FAIL max_sb cycle=%0d got=%b exp=%b", k, obs_v, exp_v);
        end
      end
      if (k == 257) begin
        checks++;
        if (bus.DI_O !== 1'b0) begin
          failures++; $display("FAIL max_early got=%b exp=0", bus.DI_O);
        end
      end
      if (k == 258) begin
        checks++;
        if (bus.DI_O !== 1'b1) begin
          failures++; $display("FAIL max_accept got=%b exp=1", bus.DI_O);
        end
      end
    end
  endtask
`else
  // Filter absent: FILT_LEN_I=50 is ignored, latency is 3 cycles.
  task automatic test_latency();
    do_reset();
    bus.FILT_LEN_I = 8'd50; bus.EDGE_SEL_I = EDGE_RISE; bus.DI_I = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL lat_sb_empty cycle=%0d", k);
      end else begin
        exp_v = exp_q.pop_front();
        obs_v = {bus.DI_O, bus.RISE_O, bus.FALL_O, bus.IRQ_O};
        if (obs_v !== exp_v) begin
          failures++; $display("FAIL lat_sb cycle=%0d got=%b exp=%b", k, obs_v, exp_v);
        end
      end
      if (k == 2) begin
        checks++;
        if (bus.DI_O !== 1'b0) begin
          failures++; $display("FAIL lat_early got=%b exp=0", bus.DI_O);
        end
      end
      if (k == 3) begin
        checks++;
        if ({bus.DI_O, bus.RISE_O} !== 2'b11) begin
          failures++; $display("FAIL lat_at3 got=%b exp=11", {bus.DI_O, bus.RISE_O});
        end
      end
      if (k == 4) begin
        checks++;
        if ({bus.RISE_O, bus.IRQ_O} !== 2'b01) begin
          failures++; $display("FAIL lat_irq got=%b exp=01", {bus.RISE_O, bus.IRQ_O});
        end
      end
    end
  endtask

  // 1-cycle pulses propagate intact; IE_I=0 masks the pad.
  task automatic test_pulses();
    do_reset();
    bus.FILT_LEN_I = 8'd50; bus.DI_I = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL pulse_sb_empty cycle=%0d", k);
      end else begin
        exp_v = exp_q.pop_front();
        obs_v = {bus.DI_O, bus.RISE_O, bus.FALL_O, bus.IRQ_O};
        if (obs_v !== exp_v) begin
          failures++; $display("FAIL pulse_sb cycle=%0d got=%b exp=%b", k, obs_v, exp_v);
        end
      end
      bus.DI_I = (k == 2 || k == 4);
      if (k == 3) begin
        checks++;
        if ({bus.DI_O, bus.RISE_O} !== 2'b11) begin
          failures++; $display("FAIL pulse_high got=%b exp=11", {bus.DI_O, bus.RISE_O});
        end
      end
      if (k == 4) begin
        checks++;
        if ({bus.DI_O, bus.FALL_O} !== 2'b01) begin
          failures++; $display("FAIL pulse_low got=%b exp=01", {bus.DI_O, bus.FALL_O});
        end
      end
      if (k >= 8) begin
        bus.IE_I = 1'b0; bus.DI_I = 1'b1;
      end
      if (k == 20) begin
        checks++;
        if (bus.DI_O !== 1'b0) begin
          failures++; $display("FAIL ie_masked got=%b exp=0", bus.DI_O);
        end
      end
    end
  endtask
`endif

  initial begin
    clk = 1'b0; rst = 1'b1; checks = 0; failures = 0;
    bus.DI_I = 1'b0; bus.IE_I = 1'b1; bus.FILT_LEN_I = '0;
    bus.EDGE_SEL_I = EDGE_NONE; bus.IRQ_CLR_I = 1'b0;
    test_reset();
`ifdef GPI_GLITCH_FILTER_EN
    test_filter_pass();
    test_glitch();
    test_zero_len_enable();
    test_len_lowered();
    test_reset_midpend();
    test_len_max();
`else
    test_latency();
    test_pulses();
`endif
    test_irq_collision();
    test_edge_sel();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
